// File: rtl/sha256_stream_hasher_pkg.sv
// Shared definitions for the streaming SHA-256 hasher: block geometry,
// initial hash value, round constants, FSM state type and a rotate helper.
package sha256_pkg;

    localparam int BLOCK_BYTES    = 64;
    localparam int LEN_FIELD_BITS = 64;

    localparam logic [255:0] SHA256_H_INIT =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CORE,
        PAD,
        DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/sha256_stream_hasher_if.sv
// Byte-stream and digest bundle between a message source (master) and the
// hasher (slave).
// Handshake: a beat transfers on a rising clk edge where s_valid && s_ready;
// the source holds s_data/s_last/s_keep stable while s_valid is high and the
// beat has not transferred; s_ready never depends combinationally on s_valid.
interface sha256_stream_hasher_if
    import sha256_pkg::*;
#(
    parameter int DATA_BYTES = 4
);
    localparam int KEEP_W = $clog2(DATA_BYTES) + 1;

    logic                    s_valid;
    logic                    s_ready;
    logic [8*DATA_BYTES-1:0] s_data;
    logic                    s_last;
    logic [KEEP_W-1:0]       s_keep;
    logic [255:0]            hash_out;
    logic                    hash_valid;
    logic                    busy;
    state_t                  dbg_state;

    modport master (
        output s_valid, s_data, s_last, s_keep,
        input  s_ready, hash_out, hash_valid, busy, dbg_state
    );

    modport slave (
        input  s_valid, s_data, s_last, s_keep,
        output s_ready, hash_out, hash_valid, busy, dbg_state
    );

endinterface

// File: rtl/sha256_stream_hasher_core.sv
// Iterative SHA-256 compression core: one round per clock, 64 rounds per
// block. Accepts a start only while idle; output_valid pulses for one cycle
// with the chained hash (Hash_in + compressed working variables).
module sha256_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         input_valid,
    input  logic [511:0] data_in,
    input  logic [255:0] Hash_in,
    output logic         output_valid,
    output logic [255:0] Hash_out
);

    logic         r_busy;
    logic [5:0]   r_round;
    logic [31:0]  r_w [0:15];
    logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [255:0] r_hin;
    logic [255:0] r_hash;
    logic         r_ov;

    logic [31:0]  w_t1, w_t2, w_new_a, w_new_e, w_w_next;

    // Round datapath and the message schedule word 16 steps ahead.
    always_comb begin
        w_t1 = r_h
             + (rotr(r_e, 6) ^ rotr(r_e, 11) ^ rotr(r_e, 25))
             + ((r_e & r_f) ^ (~r_e & r_g))
             + K[r_round]
             + r_w[0];
        w_t2 = (rotr(r_a, 2) ^ rotr(r_a, 13) ^ rotr(r_a, 22))
             + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
        w_new_a  = w_t1 + w_t2;
        w_new_e  = r_d + w_t1;
        w_w_next = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10))
                 + r_w[9]
                 + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3))
                 + r_w[0];
    end

    // Load a block when idle, then run 64 rounds and emit the chained hash.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy  <= 1'b0;
            r_round <= '0;
            r_ov    <= 1'b0;
            r_hash  <= '0;
            r_hin   <= '0;
            r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
            r_e <= '0; r_f <= '0; r_g <= '0; r_h <= '0;
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
        end else begin
            r_ov <= 1'b0;
            if (!r_busy) begin
                if (input_valid) begin
                    r_busy  <= 1'b1;
                    r_round <= '0;
                    r_hin   <= Hash_in;
                    {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= Hash_in;
                    for (int i = 0; i < 16; i++) r_w[i] <= data_in[511-32*i -: 32];
                end
            end else begin
                {r_a, r_b, r_c, r_d} <= {w_new_a, r_a, r_b, r_c};
                {r_e, r_f, r_g, r_h} <= {w_new_e, r_e, r_f, r_g};
                for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                r_w[15] <= w_w_next;
                r_round <= r_round + 6'd1;
                if (r_round == 6'd63) begin
                    r_busy <= 1'b0;
                    r_ov   <= 1'b1;
                    r_hash <= {r_hin[255:224] + w_new_a, r_hin[223:192] + r_a,
                               r_hin[191:160] + r_b,     r_hin[159:128] + r_c,
                               r_hin[127:96]  + w_new_e, r_hin[95:64]   + r_e,
                               r_hin[63:32]   + r_f,     r_hin[31:0]    + r_g};
                end
            end
        end
    end

    assign output_valid = r_ov;
    assign Hash_out     = r_hash;

endmodule

// File: rtl/sha256_stream_hasher.sv
// Streaming SHA-256 front-end: packs byte beats into 512-bit blocks, applies
// message padding and the 64-bit length field, and chains blocks through
// sha256_core until the final digest is available.
module sha256_stream_hasher
    import sha256_pkg::*;
#(
    parameter int DATA_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sha256_stream_hasher_if.slave bus
);

    localparam int KEEP_W = $clog2(DATA_BYTES) + 1;
    localparam int DATA_W = 8 * DATA_BYTES;

    state_t       r_state;
    logic [511:0] r_buf;
    logic [6:0]   r_ptr;
    logic [60:0]  r_cnt;
    logic [255:0] r_h;
    logic [255:0] r_hash_out;
    logic         r_hash_valid;
    logic         r_busy;
    logic         r_s_ready;
    logic         r_core_start;
    logic         r_final;     // block in the core is the last one of the message
    logic         r_pad_next;  // message ended exactly on a block: padding block follows
    logic         r_len_next;  // padding overflowed: a length-only block follows
    logic         r_finish;    // final chained hash is in r_h, publish next cycle

    logic         w_accept;
    logic [6:0]   w_nbytes;
    logic [6:0]   w_ptr_next;
    logic [63:0]  w_len;
    logic [511:0] w_pad_block;
    logic [511:0] w_len_block;
    logic         w_core_ov;
    logic [255:0] w_core_hash;
    logic [KEEP_W-1:0] w_keep;

    assign w_keep     = bus.s_keep;
    assign w_accept   = bus.s_valid && r_s_ready;
    assign w_nbytes   = bus.s_last ? 7'(w_keep) : 7'(DATA_BYTES);
    assign w_ptr_next = r_ptr + w_nbytes;
    assign w_len      = {r_cnt, 3'b000};
    assign w_len_block = {{(512-LEN_FIELD_BITS){1'b0}}, w_len};

    // Padded view of the buffer: 0x80 at r_ptr, zeros after, length if it fits.
    always_comb begin
        w_pad_block = r_buf;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (7'(k) == r_ptr) begin
                w_pad_block[511-8*k -: 8] = 8'h80;
            end else if (7'(k) > r_ptr) begin
                w_pad_block[511-8*k -: 8] = 8'h00;
            end
        end
        if (r_ptr <= 7'd55) begin
            w_pad_block[LEN_FIELD_BITS-1:0] = w_len;
        end
    end

    // Main control FSM with registered handshake, core start and digest outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_buf        <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_h          <= SHA256_H_INIT;
            r_hash_out   <= '0;
            r_hash_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_s_ready    <= 1'b0;
            r_core_start <= 1'b0;
            r_final      <= 1'b0;
            r_pad_next   <= 1'b0;
            r_len_next   <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            r_hash_valid <= 1'b0;
            r_core_start <= 1'b0;
            case (r_state)
                IDLE, FILL: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_buf[511 - 8*int'(r_ptr) -: DATA_W] <= bus.s_data;
                        r_ptr   <= w_ptr_next;
                        r_cnt   <= r_cnt + 61'(w_nbytes);
                        r_busy  <= 1'b1;
                        r_state <= FILL;
                        if (bus.s_last) begin
                            r_s_ready <= 1'b0;
                            r_state   <= PAD;
                        end else if (w_ptr_next == 7'(BLOCK_BYTES)) begin
                            r_s_ready    <= 1'b0;
                            r_state      <= CORE;
                            r_core_start <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    r_state      <= CORE;
                    r_core_start <= 1'b1;
                    if (r_ptr == 7'(BLOCK_BYTES)) begin
                        r_pad_next <= 1'b1;
                    end else begin
                        r_buf <= w_pad_block;
                        if (r_ptr <= 7'd55) begin
                            r_final <= 1'b1;
                        end else begin
                            r_len_next <= 1'b1;
                        end
                    end
                end
                CORE: begin
                    if (r_finish) begin
                        r_finish     <= 1'b0;
                        r_hash_out   <= r_h;
                        r_hash_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= DONE;
                    end else if (w_core_ov && !r_core_start) begin
                        r_h <= w_core_hash;
                        if (r_final) begin
                            r_final  <= 1'b0;
                            r_finish <= 1'b1;
                        end else if (r_pad_next) begin
                            r_pad_next <= 1'b0;
                            r_ptr      <= '0;
                            r_state    <= PAD;
                        end else if (r_len_next) begin
                            r_len_next   <= 1'b0;
                            r_final      <= 1'b1;
                            r_buf        <= w_len_block;
                            r_core_start <= 1'b1;
                        end else begin
                            r_ptr     <= '0;
                            r_s_ready <= 1'b1;
                            r_state   <= FILL;
                        end
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_s_ready <= 1'b1;
                    r_h       <= SHA256_H_INIT;
                    r_ptr     <= '0;
                    r_cnt     <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sha256_core u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .input_valid  (r_core_start),
        .data_in      (r_buf),
        .Hash_in      (r_h),
        .output_valid (w_core_ov),
        .Hash_out     (w_core_hash)
    );

    assign bus.s_ready    = r_s_ready;
    assign bus.hash_out   = r_hash_out;
    assign bus.hash_valid = r_hash_valid;
    assign bus.busy       = r_busy;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Directed bench for sha256_stream_hasher at DATA_BYTES = 1, 4 and 8.
module tb_sha256_stream_hasher;
    import sha256_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_A64   = 256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sha256_stream_hasher_if #(.DATA_BYTES(1)) bus1 ();
    sha256_stream_hasher_if #(.DATA_BYTES(4)) bus4 ();
    sha256_stream_hasher_if #(.DATA_BYTES(8)) bus8 ();

    sha256_stream_hasher #(.DATA_BYTES(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    sha256_stream_hasher #(.DATA_BYTES(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
    sha256_stream_hasher #(.DATA_BYTES(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));

    int n_pass = 0;
    int n_total = 0;
    int starts1 = 0, starts4 = 0, starts8 = 0;
    int hv4 = 0;
    int viol1 = 0, viol8 = 0;
    logic [511:0] last_blk4 = '0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Monitors: core starts, digest pulses, ready during CORE, illegal keep.
    always @(negedge clk) begin
        if (u_dut1.r_core_start) starts1++;
        if (u_dut4.r_core_start) begin
            starts4++;
            last_blk4 = u_dut4.r_buf;
        end
        if (u_dut8.r_core_start) starts8++;
        if (bus4.hash_valid) hv4++;
        if (bus1.dbg_state == CORE && bus1.s_ready) viol1++;
        if (bus8.dbg_state == CORE && bus8.s_ready) viol8++;
        assert (!(bus4.s_valid && !bus4.s_last && bus4.s_keep == 3'd0))
        else begin n_total++; $error("FAIL illegal_keep: keep 0 on non-last beat"); end
    end

    // ---------------- driver helpers ----------------
    task automatic set_beat(input int db, input logic v, input logic [63:0] d, input logic last, input int keep);
        case (db)
            1: begin bus1.s_valid = v; bus1.s_data = d[7:0];  bus1.s_last = last; bus1.s_keep = 1'(keep); end
            8: begin bus8.s_valid = v; bus8.s_data = d;       bus8.s_last = last; bus8.s_keep = 4'(keep); end
            default: begin bus4.s_valid = v; bus4.s_data = d[31:0]; bus4.s_last = last; bus4.s_keep = 3'(keep); end
        endcase
    endtask

    function automatic logic get_ready(input int db);
        case (db)
            1: return bus1.s_ready;
            8: return bus8.s_ready;
            default: return bus4.s_ready;
        endcase
    endfunction

    function automatic logic get_hv(input int db);
        case (db)
            1: return bus1.hash_valid;
            8: return bus8.hash_valid;
            default: return bus4.hash_valid;
        endcase
    endfunction

    function automatic logic get_busy(input int db);
        case (db)
            1: return bus1.busy;
            8: return bus8.busy;
            default: return bus4.busy;
        endcase
    endfunction

    function automatic logic [255:0] get_hash(input int db);
        case (db)
            1: return bus1.hash_out;
            8: return bus8.hash_out;
            default: return bus4.hash_out;
        endcase
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic put_beat(input int db, input logic [63:0] d, input logic last, input int keep, input bit gaps);
        int n = 0;
        set_beat(db, 1'b1, d, last, keep);
        while (!get_ready(db) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("beat_accept_timeout", 0, 1);
        @(negedge clk);
        set_beat(db, 1'b0, '0, 1'b0, 0);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_msg(input int db, input byte_q_t msg, input bit gaps, input bit with_last);
        int n = msg.size();
        int i = 0;
        do begin
            logic [63:0] d = '0;
            int k = (n - i < db) ? (n - i) : db;
            logic last = with_last && (i + db >= n);
            for (int j = 0; j < db; j++) d[8*(db-1-j) +: 8] = (i + j < n) ? msg[i+j] : 8'h00;
            put_beat(db, d, last, last ? k : db, gaps);
            i += db;
        end while (i < n);
    endtask

    task automatic wait_digest(input int db, input string tag, input logic [255:0] exp);
        int n = 0;
        while (!get_hv(db) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, get_hv(db), 1);
        check({tag, "_digest"}, get_hash(db), exp);
        check({tag, "_busy_low"}, get_busy(db), 0);
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        byte_q_t m_abc, m_empty, m_56, m_a64;
        string s56;
        int s_st, s_hv, s_st1, s_st8;

        m_abc = '{8'h61, 8'h62, 8'h63};
        m_empty = {};
        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        for (int i = 0; i < s56.len(); i++) m_56.push_back(s56[i]);
        for (int i = 0; i < 64; i++) m_a64.push_back(8'h61);

        set_beat(1, 1'b0, '0, 1'b0, 0);
        set_beat(4, 1'b0, '0, 1'b0, 0);
        set_beat(8, 1'b0, '0, 1'b0, 0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", bus4.s_ready, 0);
        check("rst_hash_valid", bus4.hash_valid, 0);
        check("rst_busy", bus4.busy, 0);
        check("rst_hash_out", bus4.hash_out, 0);
        check("rst_state", bus4.dbg_state, IDLE);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus4.s_ready, 1);

        // "abc" in one 4-byte beat with keep=3
        s_st = starts4; s_hv = hv4;
        send_msg(4, m_abc, 1'b0, 1'b1);
        check("abc_busy_high", bus4.busy, 1);
        wait_digest(4, "abc", D_ABC);
        check("abc_core_starts", starts4 - s_st, 1);
        check("abc_pulses", hv4 - s_hv, 1);

        // Empty message
        s_st = starts4;
        send_msg(4, m_empty, 1'b0, 1'b1);
        wait_digest(4, "empty", D_EMPTY);
        check("empty_core_starts", starts4 - s_st, 1);
        check("empty_block", last_blk4, {8'h80, 504'b0});

        // 56 bytes: padding spills into a length-only block
        s_st = starts4;
        send_msg(4, m_56, 1'b0, 1'b1);
        wait_digest(4, "msg56", D_56);
        check("msg56_core_starts", starts4 - s_st, 2);
        check("msg56_len_block", last_blk4, {448'b0, 64'h1c0});

        // 64 x 'a' at DATA_BYTES=1 and 8 with random gaps
        s_st1 = starts1; s_st8 = starts8;
        send_msg(1, m_a64, 1'b1, 1'b1);
        wait_digest(1, "a64_db1", D_A64);
        send_msg(8, m_a64, 1'b1, 1'b1);
        wait_digest(8, "a64_db8", D_A64);
        check("a64_db1_core_starts", starts1 - s_st1, 2);
        check("a64_db8_core_starts", starts8 - s_st8, 2);
        check("a64_db1_ready_in_core", viol1, 0);
        check("a64_db8_ready_in_core", viol8, 0);

        // Reset while the core works on block 1 of a 2-block message
        s_hv = hv4;
        send_msg(4, m_a64, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("abort_in_core", bus4.dbg_state, CORE);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_rst_ready_low", bus4.s_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_ready_high", bus4.s_ready, 1);
        check("abort_hash_out_cleared", bus4.hash_out, 0);
        check("abort_busy_low", bus4.busy, 0);
        s_st = starts4;
        send_msg(4, m_abc, 1'b0, 1'b1);
        wait_digest(4, "abort_abc", D_ABC);
        repeat (80) @(negedge clk);
        check("abort_pulses", hv4 - s_hv, 1);
        check("abort_abc_core_starts", starts4 - s_st, 1);

        // Back-to-back "abc" then empty
        s_hv = hv4;
        send_msg(4, m_abc, 1'b0, 1'b1);
        wait_digest(4, "b2b_abc", D_ABC);
        check("b2b_ready_after_done", bus4.s_ready, 1);
        send_msg(4, m_empty, 1'b0, 1'b1);
        wait_digest(4, "b2b_empty", D_EMPTY);
        check("b2b_pulses", hv4 - s_hv, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha256_stream_hasher.md
Name: sha256_stream_hasher

Overview:
Streaming SHA-256 front-end that takes a message of any length as byte beats with a valid/ready handshake. It performs FIPS 180-4 padding and splits the message into 512-bit blocks. It drives the existing sha256_core once per block, chaining the intermediate hash, and returns the final digest. It replaces hand-built single-block padding and extends hashing to multi-block messages, empty messages and parametrised input width.

Parameters:
DATA_BYTES, 4, bytes per input beat; legal values 1, 2, 4, 8 (each divides 64, so a beat never straddles a block boundary).
KEEP_W, $clog2(DATA_BYTES)+1, width of s_keep; derived, do not override.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  block accepts the beat when s_valid && s_ready
s_data  in  8*DATA_BYTES  message bytes, big-endian: first byte in the MSBs
s_last  in  1  final beat of the message
s_keep  in  KEEP_W  valid byte count on the last beat, 0..DATA_BYTES (MS bytes first); ignored and treated as DATA_BYTES when s_last=0
hash_out  out  256  final digest, H0 in the MSBs
hash_valid  out  1  one-cycle pulse when hash_out updates
busy  out  1  high from the first accepted beat until the hash_valid cycle

Behaviour:
- Reset (reset_n=0 at a posedge): state=IDLE, hash_out=0, hash_valid=0, busy=0, s_ready=0 while reset_n=0.
  - Byte counter, block buffer and chaining H are cleared and H is reloaded with the SHA-256 initial constants.
  - Reset mid-message or mid-core-operation aborts the message; any later core output_valid from the aborted block is ignored.
- States: IDLE, FILL, CORE, PAD, DONE.
- IDLE/FILL, s_ready=1:
  - Each accepted beat writes its bytes at byte pointer ptr (0..63) in the 512-bit buffer. ptr advances by DATA_BYTES, or by s_keep on the last beat.
  - The 61-bit byte count advances by the same amount and wraps mod 2^61.
  - The first accepted beat moves IDLE to FILL and sets busy.
- Block full without s_last (ptr reaches 64): go to CORE and set s_ready=0.
  - The next cycle pulses core input_valid for one cycle with data_in=buffer and Hash_in=H.
  - On core output_valid: H <= Hash_out, ptr=0, return to FILL.
- Accepted beat with s_last: s_ready=0, go to PAD. Padding uses p = ptr after the last bytes are written.
  - If p=64: hash the full block first, then build a block of 0x80, zeros and a 64-bit length.
  - Else write 0x80 at byte p and zero bytes p+1..63.
  - If p<=55: bits[63:0] = bit length (byte count<<3), and this is the final block.
  - If p>=56: hash this block, then build a final block of all zeros plus the 64-bit length.
- Final block core output_valid: H <= Hash_out. The next cycle sets hash_out <= Hash_out and pulses hash_valid for one cycle, state DONE.
  - busy drops in the hash_valid cycle; DONE goes to IDLE the following cycle, when s_ready=1 and H is reset to the initial constants.
- Latency: the core is started exactly 1 cycle after its block is ready, and at most one start is outstanding.
- Empty message: a single beat with s_last=1, s_keep=0 gives one padded block with length 0.
- s_keep=0 with s_last=0 is illegal; the behaviour is undefined and a bench assertion flags it.
- Bytes below s_keep in s_data are don't-care.
- hash_out holds its value until the next digest.

Decomposition:
- Shared package sha256_pkg holds:
  - the SHA-256 initial hash constant (256-bit);
  - BLOCK_BYTES=64 and LEN_FIELD_BITS=64;
  - the state enum {IDLE, FILL, CORE, PAD, DONE}.
- One natural sub-module: the existing sha256_core, instantiated once with clk/reset_n wired through.
- Padding and buffer logic stay inline.

Test Plan:
- "abc", DATA_BYTES=4, one beat 0x61626300, s_keep=3, s_last=1 -> hash_valid once; hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; 1 core start.
- Empty message, s_keep=0, s_last=1 -> hash_out=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; 1 core start.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 248d6a61d20638b8e5c026930c3e60 39a33ce45964ff2167f6ecedd419db06c1 (contiguous 256-bit value); exactly 2 core starts, second block carries only the length 0x1c0.
- 64 bytes of 0x61 plus random s_valid gaps, run at DATA_BYTES=1 and at 8 -> digest matches the software model; 2 core starts; s_ready=0 throughout CORE.
- Reset asserted while the core is busy on block 1 of a 2-block message, then "abc" sent -> no hash_valid for the aborted message; "abc" digest correct; s_ready=1 one cycle after reset_n rises.
- Back-to-back messages "abc" then empty -> two hash_valid pulses with the correct digests; the second digest is independent of the first (H reinitialised).
